// File: rtl/one_hot_iterator.sv
// Serialises a captured request vector into one-hot beats, one per handshake.
// Optional ONE_HOT_ITERATOR_SEQ_EN adds per-beat ordinal and burst popcount outputs.
module one_hot_iterator #(
  parameter int WIDTH      = 32,
  parameter int MSB_FIRST  = 0,
  parameter int EMIT_EMPTY = 0,
  parameter int IDX_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef ONE_HOT_ITERATOR_SEQ_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_seq,
  output logic [$clog2(WIDTH+1)-1:0] out_total
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             rdy_en_q;
  logic [WIDTH-1:0] beat;
  logic             vld, single, last, fire, cap, rdy;

  function automatic logic [WIDTH-1:0] lowest(input logic [WIDTH-1:0] v);
    return v & (~v + ONE);
  endfunction

  function automatic logic [WIDTH-1:0] highest(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) r = r | IDX_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    beat   = (MSB_FIRST != 0) ? highest(pend_q) : lowest(pend_q);
    vld    = (state_q == EMIT);
    single = (pend_q != '0) && ((pend_q & (pend_q - ONE)) == '0);
    // An EMIT state with nothing pending can only be the empty-vector beat.
    last   = vld & (single | (pend_q == '0));
    fire   = vld & out_ready;
    rdy    = rdy_en_q & ((state_q == IDLE) | (fire & last));
    cap    = in_valid & rdy;
  end

  always_comb begin
    pend_d  = pend_q;
    state_d = state_q;
    if (fire) begin
      pend_d = pend_q & ~beat;
      if (last) state_d = IDLE;
    end
    if (cap) begin
      pend_d  = in_vec;
      state_d = ((in_vec != '0) || (EMIT_EMPTY != 0)) ? EMIT : IDLE;
    end
  end

  // rdy_en_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign in_ready   = rdy;
  assign out_valid  = vld;
  assign out_onehot = vld ? beat : '0;
  assign out_index  = vld ? encode(beat) : '0;
  assign out_last   = last;
  assign out_empty  = vld & (pend_q == '0);
  assign busy       = vld;

`ifdef ONE_HOT_ITERATOR_SEQ_EN
  localparam int SEQ_W = $clog2(WIDTH+1);

  logic [SEQ_W-1:0] seq_q, seq_d, total_q, total_d;

  function automatic logic [SEQ_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [SEQ_W-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + SEQ_W'(v[i]);
    return s;
  endfunction

  always_comb begin
    seq_d   = seq_q;
    total_d = total_q;
    if (fire) seq_d = last ? '0 : seq_q + SEQ_W'(1);
    if (cap) begin
      seq_d   = '0;
      total_d = popcount(in_vec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q   <= '0;
      total_q <= '0;
    end else begin
      seq_q   <= seq_d;
      total_q <= total_d;
    end
  end

  assign out_seq   = vld ? seq_q : '0;
  assign out_total = vld ? total_q : '0;
`endif

endmodule

// File: tb/tb_one_hot_iterator.sv
// Directed bench for one_hot_iterator: three WIDTH=8 instances (LSB-first, MSB-first, empty-beat)
// driven in lockstep, with a per-instance queue of expected beats.
module tb_one_hot_iterator;

  typedef struct packed {
    logic [7:0] oh;
    logic [2:0] idx;
    logic       last;
    logic       empty;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       out_ready;
  logic       ir   [3];
  logic [7:0] oh   [3];
  logic [2:0] idx  [3];
  logic       lst  [3];
  logic       emp  [3];
  logic       ov   [3];
  logic       bsy  [3];
`ifdef ONE_HOT_ITERATOR_SEQ_EN
  logic [3:0] seq  [3];
  logic [3:0] tot  [3];
`endif

  beat_t q[3][$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  one_hot_iterator #(.WIDTH(8), .MSB_FIRST(0), .EMIT_EMPTY(0)) u_lsb (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir[0]),
    .out_onehot(oh[0]), .out_index(idx[0]), .out_last(lst[0]), .out_empty(emp[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .busy(bsy[0])
`ifdef ONE_HOT_ITERATOR_SEQ_EN
    , .out_seq(seq[0]), .out_total(tot[0])
`endif
  );

  one_hot_iterator #(.WIDTH(8), .MSB_FIRST(1), .EMIT_EMPTY(0)) u_msb (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir[1]),
    .out_onehot(oh[1]), .out_index(idx[1]), .out_last(lst[1]), .out_empty(emp[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .busy(bsy[1])
`ifdef ONE_HOT_ITERATOR_SEQ_EN
    , .out_seq(seq[1]), .out_total(tot[1])
`endif
  );

  one_hot_iterator #(.WIDTH(8), .MSB_FIRST(0), .EMIT_EMPTY(1)) u_emp (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir[2]),
    .out_onehot(oh[2]), .out_index(idx[2]), .out_last(lst[2]), .out_empty(emp[2]),
    .out_valid(ov[2]), .out_ready(out_ready), .busy(bsy[2])
`ifdef ONE_HOT_ITERATOR_SEQ_EN
    , .out_seq(seq[2]), .out_total(tot[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats for one captured vector, in emission order.
  task automatic push(input int id, input logic [7:0] v, input bit msb, input bit ee);
    beat_t b;
    int n, cnt, i;
    n = 0;
    cnt = 0;
    for (int k = 0; k < 8; k++) n += int'(v[k]);
    if (n == 0) begin
      if (ee) begin
        b = '{oh: 8'h00, idx: 3'd0, last: 1'b1, empty: 1'b1};
        q[id].push_back(b);
      end
      return;
    end
    for (int k = 0; k < 8; k++) begin
      i = msb ? 7 - k : k;
      if (v[i]) begin
        cnt++;
        b.oh    = 8'h01 << i;
        b.idx   = 3'(i);
        b.last  = (cnt == n);
        b.empty = 1'b0;
        q[id].push_back(b);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the capture edge.
  task automatic send(input logic [7:0] v);
    int n;
    in_vec   = v;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(ir[0] && ir[1] && ir[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
    else begin
      push(0, v, 1'b0, 1'b0);
      push(1, v, 1'b1, 1'b0);
      push(2, v, 1'b0, 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() != 0 || ov[0] || ov[1] || ov[2]) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'(1));
  endtask

  // Scoreboard: every valid beat must match the queue head; pop on handshake.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          if (q[d].size() == 0) chk($sformatf("spurious_beat%0d", d), 32'(ov[d]), 32'(0));
          else begin
            e = q[d][0];
            chk($sformatf("onehot%0d", d), 32'(oh[d]), 32'(e.oh));
            chk($sformatf("index%0d", d), 32'(idx[d]), 32'(e.idx));
            chk($sformatf("last%0d", d), 32'(lst[d]), 32'(e.last));
            chk($sformatf("empty%0d", d), 32'(emp[d]), 32'(e.empty));
            if (out_ready) void'(q[d].pop_front());
          end
        end else begin
          chk($sformatf("idle_outs%0d", d), {19'd0, oh[d], idx[d], lst[d], emp[d]}, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [7:0] pat;
    rst       = 1'b1;
    in_vec    = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_in_ready%0d", d), 32'(ir[d]), 32'(0));
      chk($sformatf("rst_valid%0d", d), 32'(ov[d]), 32'(0));
      chk($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'(0));
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("ready_before_edge", 32'(ir[0]), 32'(0));
    @(posedge clk);
    #1;
    chk("ready_after_release", 32'(ir[0]), 32'(1));

    // LSB-first and MSB-first ordering with out_ready held high
    send(8'hD2);
    chk("first_beat_latency", 32'(ov[0]), 32'(1));
    chk("first_idx_lsb", 32'(idx[0]), 32'(1));
    chk("first_idx_msb", 32'(idx[1]), 32'(7));
    repeat (3) @(posedge clk);
    #1;
    chk("fourth_idx_lsb", 32'(idx[0]), 32'(7));
    chk("fourth_last_lsb", 32'(lst[0]), 32'(1));
    chk("fourth_ready_lsb", 32'(ir[0]), 32'(1));
    chk("fourth_idx_msb", 32'(idx[1]), 32'(1));
    wait_drain();

    // Stalled consumer: outputs must hold; scoreboard catches loss/duplication
    pat = 8'b1110_1001;
    send(8'hD2);
    for (int k = 0; k < 8; k++) begin
      out_ready = pat[k];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back vectors, no bubble
    send(8'h81);
    chk("b2b_first_idx", 32'(idx[0]), 32'(0));
    send(8'h01);
    chk("b2b_no_bubble", 32'(ov[0]), 32'(1));
    chk("b2b_second_idx", 32'(idx[0]), 32'(0));
    chk("b2b_second_last", 32'(lst[0]), 32'(1));
    wait_drain();

    // All-zero vector
    send(8'h00);
    chk("zero_dropped", 32'(ov[0]), 32'(0));
    chk("zero_ready", 32'(ir[0]), 32'(1));
    chk("zero_empty_valid", 32'(ov[2]), 32'(1));
    chk("zero_empty_flag", 32'(emp[2]), 32'(1));
    chk("zero_empty_last", 32'(lst[2]), 32'(1));
    wait_drain();

    // Reset mid-burst
    send(8'hFF);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_idx_lsb", 32'(idx[0]), 32'(2));
    chk("pre_rst_idx_msb", 32'(idx[1]), 32'(5));
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid_rst_valid%0d", d), 32'(ov[d]), 32'(0));
      chk($sformatf("mid_rst_ready%0d", d), 32'(ir[d]), 32'(0));
      q[d].delete();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h04);
    chk("post_rst_idx", 32'(idx[0]), 32'(2));
    chk("post_rst_last", 32'(lst[0]), 32'(1));
    wait_drain();

    for (int d = 0; d < 3; d++) chk($sformatf("queue_empty%0d", d), 32'(q[d].size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
